// File: rtl/pkt_rr_sched_if.sv
// Bus bundle for pkt_rr_sched: per-channel FIFO read side plus merged output stream.
//   pkt_rdy/dat_empty/dat_q : per-channel message/data FIFO status and show-ahead words
//   dat_rdreq/msg_rdreq     : per-channel data read ack and message pop (combinational)
//   out_rdy                 : downstream ready
//   data_d*/chan_d          : registered merged output stream with source channel
//   err_sop/err_len         : sticky framing error flags
interface pkt_rr_sched_if #(
   parameter int unsigned NCH = 3,
   parameter int unsigned DW  = 16,
   parameter int unsigned CHW = 2
);
   logic [NCH-1:0]        pkt_rdy;
   logic [NCH-1:0]        dat_empty;
   logic [NCH*(DW+2)-1:0] dat_q;
   logic [NCH-1:0]        dat_rdreq;
   logic [NCH-1:0]        msg_rdreq;
   logic                  out_rdy;
   logic [DW-1:0]         data_d;
   logic                  data_d_sop;
   logic                  data_d_eop;
   logic                  data_d_vld;
   logic [CHW-1:0]        chan_d;
   logic                  err_sop;
   logic                  err_len;

   modport master (
      input  pkt_rdy, dat_empty, dat_q, out_rdy,
      output dat_rdreq, msg_rdreq, data_d, data_d_sop, data_d_eop, data_d_vld,
             chan_d, err_sop, err_len
   );

   modport slave (
      output pkt_rdy, dat_empty, dat_q, out_rdy,
      input  dat_rdreq, msg_rdreq, data_d, data_d_sop, data_d_eop, data_d_vld,
             chan_d, err_sop, err_len
   );
endinterface

// File: rtl/pkt_rr_sched.sv
// Round-robin packet scheduler: picks a channel with a complete packet, drains
// exactly one packet from its show-ahead data FIFO, pops its message FIFO on eop,
// and presents the words on a registered merged stream tagged with the channel.
//   clk_d, rst_n : clock, asynchronous active-low reset
//   bus          : pkt_rr_sched_if master (FIFO read side, output stream, error flags)
module pkt_rr_sched #(
   parameter int unsigned NCH    = 3,
   parameter int unsigned DW     = 16,
   parameter int unsigned CHW    = 2,
   parameter int unsigned MAXLEN = 1024
) (
   input  logic           clk_d,
   input  logic           rst_n,
   pkt_rr_sched_if.master bus
);
   localparam int unsigned WW = DW + 2;
   localparam int unsigned CW = $clog2(MAXLEN + 1);

   typedef enum logic [0:0] {IDLE, XFER} state_e;

   state_e         state, state_nxt;
   logic [CHW-1:0] sel, last_grant, grant_c;
   logic           grant_vld_c;
   logic [CW-1:0]  cnt;
   logic [WW-1:0]  word_c;
   logic           empty_c;
   logic           rd_c, eop_rd_c, len_hit_c, sop_bad_c;

   // Selected channel's head word and empty flag
   always_comb begin
      word_c  = '0;
      empty_c = 1'b1;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (sel == CHW'(i)) begin
            word_c  = bus.dat_q[i*WW +: WW];
            empty_c = bus.dat_empty[i];
         end
      end
   end

   // Round-robin search: first ready channel above last_grant, else lowest ready one
   always_comb begin
      grant_c     = last_grant;
      grant_vld_c = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!grant_vld_c && bus.pkt_rdy[i] && (CHW'(i) > last_grant)) begin
            grant_c     = CHW'(i);
            grant_vld_c = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!grant_vld_c && bus.pkt_rdy[i]) begin
            grant_c     = CHW'(i);
            grant_vld_c = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and combinational FIFO read/pop strobes
   always_comb begin
      state_nxt     = state;
      rd_c          = 1'b0;
      eop_rd_c      = 1'b0;
      len_hit_c     = 1'b0;
      bus.dat_rdreq = '0;
      bus.msg_rdreq = '0;
      case (state)
         IDLE: begin
            if (grant_vld_c) state_nxt = XFER;
         end
         XFER: begin
            rd_c      = !empty_c && bus.out_rdy;
            eop_rd_c  = rd_c && word_c[DW];
            // Last permitted word without eop: abandon the packet, leave its message queued
            len_hit_c = rd_c && !word_c[DW] && (cnt == CW'(MAXLEN - 1));
            for (int unsigned i = 0; i < NCH; i++) begin
               if (sel == CHW'(i)) begin
                  bus.dat_rdreq[i] = rd_c;
                  bus.msg_rdreq[i] = eop_rd_c;
               end
            end
            if (eop_rd_c || len_hit_c) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // sop must appear on the first word of the packet and nowhere else
   assign sop_bad_c = rd_c && (word_c[DW+1] != (cnt == '0));

   // Grant bookkeeping, word counter, registered output stream and sticky errors
   always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
         sel            <= '0;
         last_grant     <= CHW'(NCH - 1);
         cnt            <= '0;
         bus.data_d     <= '0;
         bus.data_d_sop <= 1'b0;
         bus.data_d_eop <= 1'b0;
         bus.data_d_vld <= 1'b0;
         bus.chan_d     <= '0;
         bus.err_sop    <= 1'b0;
         bus.err_len    <= 1'b0;
      end else begin
         if ((state == IDLE) && grant_vld_c) sel <= grant_c;
         if (eop_rd_c || len_hit_c) begin
            last_grant <= sel;
            cnt        <= '0;
         end else if (rd_c) begin
            cnt <= cnt + CW'(1);
         end
         bus.data_d_vld <= rd_c;
         bus.data_d     <= rd_c ? word_c[DW-1:0] : '0;
         bus.data_d_sop <= rd_c && word_c[DW+1];
         bus.data_d_eop <= rd_c && word_c[DW];
         if (rd_c)      bus.chan_d  <= sel;
         if (sop_bad_c) bus.err_sop <= 1'b1;
         if (len_hit_c) bus.err_len <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pkt_rr_sched.sv
// Testbench for pkt_rr_sched: models per-channel show-ahead data FIFOs and message
// FIFOs, queues expected output words and message pops, and checks them as the
// scheduler produces them.
module tb_pkt_rr_sched;
   localparam int unsigned NCH    = 3;
   localparam int unsigned DW     = 16;
   localparam int unsigned CHW    = 2;
   localparam int unsigned MAXLEN = 8;
   localparam int unsigned WW     = DW + 2;
   localparam int unsigned EW     = CHW + WW;

   logic clk_d = 1'b0;
   logic rst_n;

   always #5 clk_d = ~clk_d;

   pkt_rr_sched_if #(.NCH(NCH), .DW(DW), .CHW(CHW)) bus ();

   pkt_rr_sched #(.NCH(NCH), .DW(DW), .CHW(CHW), .MAXLEN(MAXLEN)) dut (
      .clk_d (clk_d),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [WW-1:0]  fq [NCH][$];
   int             msg_cnt [NCH];
   logic [EW-1:0]  exp_q [$];
   logic [NCH-1:0] msg_exp [$];
   logic [NCH-1:0] prev_mr;
   int             total;
   int             bad;
   int             msg_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Present FIFO state to the DUT
   task automatic drive_inputs();
      logic [NCH*WW-1:0] q;
      logic [NCH-1:0]    pr, em;
      q  = '0;
      pr = '0;
      em = '0;
      for (int i = 0; i < NCH; i++) begin
         pr[i] = (msg_cnt[i] > 0);
         em[i] = (fq[i].size() == 0);
         if (fq[i].size() != 0) q[i*WW +: WW] = fq[i][0];
      end
      bus.pkt_rdy   = pr;
      bus.dat_empty = em;
      bus.dat_q     = q;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NCH; i++) begin
         fq[i].delete();
         msg_cnt[i] = 0;
      end
      exp_q.delete();
      msg_exp.delete();
      prev_mr = '0;
      drive_inputs();
   endtask

   task automatic load_pkt(input int ch, input int n, input logic [DW-1:0] base, input bit sop_ok);
      logic s, e;
      for (int w = 0; w < n; w++) begin
         s = (w == 0) && sop_ok;
         e = (w == n - 1);
         fq[ch].push_back({s, e, DW'(base + DW'(w))});
      end
      msg_cnt[ch]++;
      drive_inputs();
   endtask

   task automatic exp_pkt(input int ch, input int n, input logic [DW-1:0] base, input bit sop_ok,
                          input int w_lo, input int w_hi);
      logic s, e;
      for (int w = w_lo; w <= w_hi; w++) begin
         s = (w == 0) && sop_ok;
         e = (w == n - 1);
         exp_q.push_back({CHW'(ch), s, e, DW'(base + DW'(w))});
      end
   endtask

   // One clock: sample strobes before the edge, update FIFO model after, score outputs
   task automatic tick(output logic [NCH-1:0] rd, output logic [NCH-1:0] mr);
      logic [EW-1:0] e;
      #1;
      rd = bus.dat_rdreq;
      mr = bus.msg_rdreq;
      @(posedge clk_d);
      #1;
      for (int i = 0; i < NCH; i++) begin
         if (rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
         if (mr[i] && msg_cnt[i] > 0) msg_cnt[i]--;
      end
      drive_inputs();
      check("rd_onehot", 32'($countones(rd) <= 1), 32'(1));
      if (prev_mr != '0) check("pkt_gap", 32'(rd), 32'(0));
      if (mr != '0) begin
         msg_seen++;
         if (msg_exp.size() == 0) check("msg_extra", 32'(mr), 32'(0));
         else                     check("msg_order", 32'(mr), 32'(msg_exp.pop_front()));
      end
      if (bus.data_d_vld) begin
         if (exp_q.size() == 0) begin
            check("word_extra", 32'(bus.data_d_vld), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("word", 32'({bus.chan_d, bus.data_d_sop, bus.data_d_eop, bus.data_d}), 32'(e));
         end
      end else begin
         check("idle_out", 32'({bus.data_d_sop, bus.data_d_eop, bus.data_d}), 32'(0));
      end
      prev_mr = mr;
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic [NCH-1:0] rd, mr;
      int n;
      n = 0;
      while ((exp_q.size() != 0 || msg_exp.size() != 0) && n < budget) begin
         tick(rd, mr);
         n++;
      end
      check({tag, "_drain"}, 32'(exp_q.size() + msg_exp.size()), 32'(0));
      tick(rd, mr);
      tick(rd, mr);
   endtask

   task automatic check_zero(input string tag);
      check(tag, 32'({bus.data_d_vld, bus.data_d_sop, bus.data_d_eop, bus.data_d, bus.chan_d,
                      bus.err_sop, bus.err_len, bus.dat_rdreq, bus.msg_rdreq}), 32'(0));
   endtask

   task automatic reset_dut();
      logic [NCH-1:0] rd, mr;
      rst_n = 1'b0;
      bus.out_rdy = 1'b1;
      clear_model();
      tick(rd, mr);
      tick(rd, mr);
      check_zero("reset_state");
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NCH-1:0] rd, mr;
      int             m0;
      total    = 0;
      bad      = 0;
      msg_seen = 0;
      rst_n    = 1'b0;
      bus.out_rdy = 1'b1;
      clear_model();
      reset_dut();

      // Single 4-word packet on channel 1
      load_pkt(1, 4, 16'h1100, 1'b1);
      exp_pkt(1, 4, 16'h1100, 1'b1, 0, 3);
      msg_exp.push_back(3'b010);
      tick(rd, mr);
      check("t1_idle", 32'(rd), 32'(0));
      for (int k = 0; k < 4; k++) begin
         tick(rd, mr);
         check("t1_rd", 32'(rd), 32'(3'b010));
         check("t1_msg", 32'(mr), (k == 3) ? 32'(3'b010) : 32'(0));
      end
      tick(rd, mr);
      check("t1_after", 32'(rd), 32'(0));
      check("t1_drain", 32'(exp_q.size()), 32'(0));
      check("t1_chan", 32'(bus.chan_d), 32'(1));
      tick(rd, mr);
      check("t1_vld_off", 32'(bus.data_d_vld), 32'(0));

      // Two 3-word packets on every channel from reset: grants 0,1,2,0,1,2
      reset_dut();
      for (int p = 0; p < 2; p++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            load_pkt(ch, 3, DW'(16'h2000 + p * 16'h100 + ch * 16'h10), 1'b1);
            exp_pkt(ch, 3, DW'(16'h2000 + p * 16'h100 + ch * 16'h10), 1'b1, 0, 2);
            msg_exp.push_back(NCH'(1) << ch);
         end
      end
      m0 = msg_seen;
      wait_done("t2", 60);
      check("t2_msgs", 32'(msg_seen - m0), 32'(6));

      // Backpressure mid-packet on channel 0
      load_pkt(0, 5, 16'h3300, 1'b1);
      exp_pkt(0, 5, 16'h3300, 1'b1, 0, 4);
      msg_exp.push_back(3'b001);
      tick(rd, mr);
      check("t3_idle", 32'(rd), 32'(0));
      tick(rd, mr);
      check("t3_rd0", 32'(rd), 32'(3'b001));
      tick(rd, mr);
      check("t3_rd1", 32'(rd), 32'(3'b001));
      bus.out_rdy = 1'b0;
      check("t3_inflight", 32'({bus.data_d_vld, bus.data_d}), 32'({1'b1, 16'h3301}));
      for (int k = 0; k < 3; k++) begin
         tick(rd, mr);
         check("t3_stall_rd", 32'(rd), 32'(0));
         check("t3_stall_vld", 32'(bus.data_d_vld), 32'(0));
      end
      bus.out_rdy = 1'b1;
      wait_done("t3", 30);

      // Missing sop on channel 2
      check("t4_err_sop_pre", 32'(bus.err_sop), 32'(0));
      load_pkt(2, 3, 16'h4400, 1'b0);
      exp_pkt(2, 3, 16'h4400, 1'b0, 0, 2);
      msg_exp.push_back(3'b100);
      wait_done("t4", 30);
      check("t4_err_sop", 32'(bus.err_sop), 32'(1));
      tick(rd, mr);
      tick(rd, mr);
      check("t4_err_sop_sticky", 32'(bus.err_sop), 32'(1));
      check("t4_err_len", 32'(bus.err_len), 32'(0));

      // Over-length packet on channel 0 while channel 1 waits
      load_pkt(0, 10, 16'h5500, 1'b1);
      load_pkt(1, 3, 16'h5600, 1'b1);
      exp_pkt(0, 10, 16'h5500, 1'b1, 0, 7);
      exp_pkt(1, 3, 16'h5600, 1'b1, 0, 2);
      exp_pkt(0, 10, 16'h5500, 1'b1, 8, 9);
      msg_exp.push_back(3'b010);
      msg_exp.push_back(3'b001);
      tick(rd, mr);
      check("t5_idle", 32'(rd), 32'(0));
      for (int k = 0; k < 8; k++) begin
         check("t5_err_len_pre", 32'(bus.err_len), 32'(0));
         tick(rd, mr);
         check("t5_rd", 32'(rd), 32'(3'b001));
         check("t5_no_msg", 32'(mr), 32'(0));
      end
      check("t5_err_len", 32'(bus.err_len), 32'(1));
      tick(rd, mr);
      check("t5_back_idle", 32'(rd), 32'(0));
      tick(rd, mr);
      check("t5_next_grant", 32'(rd), 32'(3'b010));
      wait_done("t5", 40);
      check("t5_err_len_sticky", 32'(bus.err_len), 32'(1));

      // Reset during word 2 of a 5-word packet on channel 1
      load_pkt(1, 5, 16'h6600, 1'b1);
      exp_pkt(1, 5, 16'h6600, 1'b1, 0, 1);
      tick(rd, mr);
      check("t6_idle", 32'(rd), 32'(0));
      tick(rd, mr);
      check("t6_rd0", 32'(rd), 32'(3'b010));
      tick(rd, mr);
      check("t6_rd1", 32'(rd), 32'(3'b010));
      rst_n = 1'b0;
      #1;
      check_zero("t6_reset_now");
      check("t6_partial", 32'(exp_q.size()), 32'(0));
      clear_model();
      tick(rd, mr);
      tick(rd, mr);
      load_pkt(1, 3, 16'h6700, 1'b1);
      load_pkt(0, 3, 16'h6800, 1'b1);
      exp_pkt(0, 3, 16'h6800, 1'b1, 0, 2);
      exp_pkt(1, 3, 16'h6700, 1'b1, 0, 2);
      msg_exp.push_back(3'b001);
      msg_exp.push_back(3'b010);
      rst_n = 1'b1;
      tick(rd, mr);
      check("t6_idle2", 32'(rd), 32'(0));
      tick(rd, mr);
      check("t6_prio", 32'(rd), 32'(3'b001));
      wait_done("t6", 30);
      check("t6_err_clear", 32'({bus.err_sop, bus.err_len}), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pkt_rr_sched.md
Name: pkt_rr_sched

Overview:
- Read-side packet scheduler in the clk_d domain for the per-channel data-FIFO + message-FIFO ingress structure.
- Each channel has a show-ahead data FIFO with words {sop, eop, data} and a message FIFO holding one entry per complete packet.
- The block picks one channel with a complete packet using round-robin, drains exactly one packet from it, and pops that channel's message entry on the eop word.
- It drives the registered merged output stream with a channel tag, honours downstream ready, and flags framing errors.

Parameters:
- NCH, 3, number of input channels (2..4).
- DW, 16, payload width.
- CHW, 2, width of chan_d; must satisfy 2**CHW >= NCH.
- MAXLEN, 1024, maximum words per packet before the length error fires.

Ports:
- clk_d  in  1  read-side clock.
- rst_n  in  1  reset.
- pkt_rdy  in  NCH  per channel, high when its message FIFO is not empty (a complete packet is queued).
- dat_empty  in  NCH  per channel data FIFO rdempty.
- dat_q  in  NCH*(DW+2)  flattened show-ahead FIFO outputs; channel i occupies bits [i*(DW+2) +: DW+2] = {sop, eop, data}.
- dat_rdreq  out  NCH  data FIFO read acknowledge, combinational.
- msg_rdreq  out  NCH  message FIFO pop, combinational.
- out_rdy  in  1  downstream ready.
- data_d  out  DW  output payload.
- data_d_sop  out  1  output start of packet.
- data_d_eop  out  1  output end of packet.
- data_d_vld  out  1  output valid.
- chan_d  out  CHW  source channel of the current output word.
- err_sop  out  1  sticky error flag.
- err_len  out  1  sticky error flag.

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock clk_d. All outputs reset to 0. Internal last_grant resets to NCH-1, so channel 0 wins the first arbitration. State resets to IDLE and the word counter to 0.
- States: IDLE and XFER.
- IDLE behaviour:
  - If any pkt_rdy bit is high, grant the first set bit searching from last_grant+1 upward, with wrap-around.
  - Register the grant in sel and move to XFER.
  - No FIFO reads occur in IDLE.
- XFER behaviour:
  - dat_rdreq[sel] = !dat_empty[sel] && out_rdy. All other dat_rdreq bits are 0.
  - Each accepted read increments the word counter.
  - msg_rdreq[sel] = dat_rdreq[sel] && eop bit of dat_q[sel]. It pulses exactly once per packet.
  - On that eop read: last_grant <= sel, word counter <= 0, state <= IDLE.
- Output latency and values:
  - One cycle of latency: data_d_vld(t+1) = |dat_rdreq(t).
  - data_d, sop and eop register the selected channel's fields when a read occurs. Otherwise they are 0.
  - chan_d loads sel on each read and holds its value otherwise.
- Backpressure:
  - Ready-latency is 1. When out_rdy drops, the word read in the previous cycle is still presented, and downstream must accept it.
  - No further reads happen until out_rdy returns high.
- Empty data FIFO mid-packet: with pkt_rdy asserted this cannot legally happen. If it does, stall in XFER (no reads) until data arrives.
- Packet gap: there is a minimum of one IDLE cycle between packets. Back-to-back packets from the same channel are allowed only when no other channel has pkt_rdy.
- Arbitration timing: pkt_rdy changes during XFER are ignored. Arbitration samples only in IDLE.
- err_sop:
  - Set when the first word read in XFER (counter == 0) has sop = 0, or a later word has sop = 1.
  - The data is still forwarded unchanged.
- err_len:
  - Set when the counter reaches MAXLEN with no eop read.
  - The block then returns to IDLE without popping the message FIFO.
  - last_grant <= sel, so the channel loses its turn.
- Sticky flags: err_sop and err_len clear only on reset.
- Reset mid-packet: all state clears immediately, and any partial output is abandoned. FIFO recovery is handled by system-level reset.

Test Plan:
- Single packet of 4 words on ch1 only (sop on word 0, eop on word 3) -> IDLE one cycle, then 4 consecutive dat_rdreq[1] pulses. msg_rdreq[1] fires on the 4th. Output is vld for 4 cycles starting 1 cycle after the first read, chan_d = 1, sop on the first output word, eop on the last.
- All three channels hold 2 packets of 3 words each from reset -> grant order 0,1,2,0,1,2. Exactly 6 msg_rdreq pulses, with one idle cycle between packets.
- out_rdy low for 3 cycles mid-packet -> no dat_rdreq during those cycles. Exactly one in-flight word appears, then data_d_vld = 0 until out_rdy rises. No word is lost or duplicated; data matches input order.
- Channel 2 packet with sop missing on the first word -> err_sop = 1 and stays 1. The packet is still fully forwarded and msg_rdreq[2] pops once.
- MAXLEN = 8 and a 10-word packet with eop on word 9 -> err_len set after 8 reads. The block returns to IDLE, msg_rdreq is never pulsed for that channel, and the next grant goes to another ready channel.
- rst_n asserted during word 2 of a 5-word packet -> all outputs 0 immediately. After release, channel 0 has priority; last_grant has reset to NCH-1.
